// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, IDLE/RUN/HALT sequencing and a writable branch-target table.
// Optional PCBU_ABS_TARGET_EN adds wr_abs and per-entry absolute-target mode bits.
module pc_branch_unit #(
   parameter int D = 12,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         stall,
   input  logic         branch,
   input  logic [N-1:0] how_high,
   input  logic         halt_req,
   input  logic         wr_en,
   input  logic [N-1:0] wr_addr,
   input  logic [D-1:0] wr_data,
`ifdef PCBU_ABS_TARGET_EN
   input  logic         wr_abs,
`endif
   output logic [D-1:0] target,
   output logic [D-1:0] prog_counter,
   output logic         running,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
   state_t       state_q, state_d;
   logic [D-1:0] pc_q, pc_d, br_pc;
   logic         running_q, done_q;
   logic [D-1:0] tbl_q [2**N];
`ifdef PCBU_ABS_TARGET_EN
   logic [2**N-1:0] mode_q;
   assign br_pc = mode_q[how_high] ? tbl_q[how_high] : pc_q + tbl_q[how_high];
`else
   assign br_pc = pc_q + tbl_q[how_high];
`endif
   assign target       = tbl_q[how_high];
   assign prog_counter = pc_q;
   assign running      = running_q;
   assign done         = done_q;
   // next state and PC; start wins in every state, RUN resolves halt > stall > branch > increment
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (start) begin
         state_d = RUN;
         pc_d    = '0;
      end else if (state_q == RUN) begin
         if (halt_req) state_d = HALT;
         else if (!stall) pc_d = branch ? br_pc : pc_q + D'(1);
      end
   end
   // state, PC and decoded status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         running_q <= state_d == RUN;
         done_q    <= state_d == HALT;
      end
   end
   // target table: defaults on reset, written on wr_en with no read bypass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**N; i++)
            tbl_q[i] <= i == 0 ? ~D'(4) : i == 1 ? D'(20) : i == 2 ? {D{1'b1}} : '0;
`ifdef PCBU_ABS_TARGET_EN
         mode_q <= '0;
`endif
      end else if (wr_en) begin
         tbl_q[wr_addr] <= wr_data;
`ifdef PCBU_ABS_TARGET_EN
         mode_q[wr_addr] <= wr_abs;
`endif
      end
   end
endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: directed stimulus with a queue-based scoreboard for pc_branch_unit.
module tb_pc_branch_unit;
   logic        clk, rst_n, start, stall, branch, halt_req, wr_en;
   logic [2:0]  how_high, wr_addr;
   logic [11:0] wr_data, target, prog_counter;
   logic        running, done;
`ifdef PCBU_ABS_TARGET_EN
   logic        wr_abs;
`endif
   typedef struct {
      string       nm;
      logic [11:0] pc;
      logic        r, d, tc;
      logic [11:0] t;
   } exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0;
   event chk_ev;
   logic [11:0] defs [8] = '{12'hFFB, 12'h014, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};

   pc_branch_unit #(.D(12), .N(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .branch(branch),
      .how_high(how_high), .halt_req(halt_req), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data),
`ifdef PCBU_ABS_TARGET_EN
      .wr_abs(wr_abs),
`endif
      .target(target), .prog_counter(prog_counter), .running(running), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog pc=%h expected simulation end", prog_counter);
      $fatal(1);
   end

   // monitor: every pushed expectation is checked just after the next edge (or on demand)
   initial forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         if (prog_counter !== e.pc || running !== e.r || done !== e.d || (e.tc && target !== e.t)) begin
            errors++;
            $display("FAIL %s got pc=%h run=%b done=%b tgt=%h expected pc=%h run=%b done=%b tgt=%h(chk=%b)",
                     e.nm, prog_counter, running, done, target, e.pc, e.r, e.d, e.t, e.tc);
         end
      end
   end

   task automatic expect_o(input string nm, input logic [11:0] pc, input logic r, input logic d,
                           input logic tc = 1'b0, input logic [11:0] t = 12'h000);
      exp_t e;
      e = '{nm, pc, r, d, tc, t};
      q.push_back(e);
   endtask

   task automatic clr;
      start = 0; stall = 0; branch = 0; halt_req = 0; wr_en = 0;
      how_high = 0; wr_addr = 0; wr_data = 0;
`ifdef PCBU_ABS_TARGET_EN
      wr_abs = 0;
`endif
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
      clr();
   endtask

   initial begin
      rst_n = 0;
      clr();
      @(negedge clk);
      for (int h = 0; h < 8; h++) begin
         how_high = 3'(h);
         expect_o("rst_default", 12'h000, 0, 0, 1, defs[h]);
         tick();
      end
      rst_n = 1;
      for (int k = 0; k < 5; k++) begin
         branch = 1; how_high = 1; halt_req = k[0];
         expect_o("idle_hold", 12'h000, 0, 0);
         tick();
      end
      start = 1; expect_o("start", 12'h000, 1, 0); tick();
      for (int k = 1; k <= 4; k++) begin
         expect_o("seq", 12'(k), 1, 0);
         tick();
      end
      branch = 1; how_high = 2; expect_o("br_minus1", 12'h003, 1, 0); tick();
      branch = 1; how_high = 0; expect_o("br_minus5", 12'hFFE, 1, 0); tick();
      branch = 1; how_high = 1; expect_o("br_plus20", 12'h012, 1, 0); tick();
      branch = 1; how_high = 3; expect_o("br_zero", 12'h012, 1, 0); tick();
      stall = 1; wr_en = 1; wr_addr = 1; wr_data = 12'hFED; how_high = 1;
      expect_o("stall_write", 12'h012, 1, 0, 1, 12'hFED); tick();
      branch = 1; how_high = 1; expect_o("br_to_fff", 12'hFFF, 1, 0); tick();
      expect_o("wrap", 12'h000, 1, 0); tick();
      expect_o("seq_after_wrap", 12'h001, 1, 0); tick();
      start = 1; halt_req = 1; branch = 1; how_high = 2;
      expect_o("prio_start", 12'h000, 1, 0); tick();
      expect_o("seq_prio", 12'h001, 1, 0); tick();
      halt_req = 1; stall = 1; expect_o("halt", 12'h001, 0, 1); tick();
      branch = 1; how_high = 2; halt_req = 1; expect_o("halt_hold", 12'h001, 0, 1); tick();
      start = 1; expect_o("restart", 12'h000, 1, 0); tick();
      expect_o("seq_r1", 12'h001, 1, 0); tick();
      expect_o("seq_r2", 12'h002, 1, 0); tick();
      wr_en = 1; wr_addr = 5; wr_data = 12'h00A; branch = 1; how_high = 5;
      expect_o("no_bypass", 12'h002, 1, 0, 1, 12'h00A); tick();
      branch = 1; how_high = 5; expect_o("br_new_entry", 12'h00C, 1, 0); tick();
      stall = 1; wr_en = 1; wr_addr = 6; wr_data = 12'h02B;
      expect_o("stall_write6", 12'h00C, 1, 0); tick();
      branch = 1; how_high = 6; wr_en = 1; wr_addr = 0; wr_data = 12'h123;
      expect_o("br_to_037", 12'h037, 1, 0); tick();
      how_high = 0;
      #1 rst_n = 0;
      expect_o("async_reset", 12'h000, 0, 0, 1, 12'hFFB);
      ->chk_ev;
      #2 rst_n = 1;
      how_high = 5; expect_o("post_rst_e5", 12'h000, 0, 0, 1, 12'h000); tick();
      how_high = 1; expect_o("post_rst_e1", 12'h000, 0, 0, 1, 12'h014); tick();
`ifdef PCBU_ABS_TARGET_EN
      start = 1; expect_o("abs_start", 12'h000, 1, 0); tick();
      stall = 1; wr_en = 1; wr_addr = 4; wr_data = 12'h100; wr_abs = 1; how_high = 4;
      expect_o("abs_write", 12'h000, 1, 0, 1, 12'h100); tick();
      branch = 1; how_high = 4; expect_o("abs_branch", 12'h100, 1, 0); tick();
      branch = 1; how_high = 2; expect_o("rel_after_abs", 12'h0FF, 1, 0); tick();
`endif
      tick();
      tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
